// File: rtl/memory_bank.sv
// memory_bank: DEPTH x WIDTH register-file storage with a synchronous write
// port, a registered read port with valid strobe, and a sequenced clear that
// zeroes one word per cycle while busy is high.
module memory_bank #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic              drop,
  output logic              addr_err
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic wr_in_range;
  logic rd_in_range;
  logic bypass_hit;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
  // A same-cycle write to the read address forwards the new data, unless a
  // clear request in the same cycle discards that write.
  assign bypass_hit  = wr_en && !clr_req && (wr_addr == rd_addr);

  // Storage, clear-sweep FSM and all registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      drop     <= 1'b0;
      addr_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      rd_valid <= 1'b0;
      clr_done <= 1'b0;
      drop     <= 1'b0;
      addr_err <= 1'b0;

      case (state)
        IDLE: begin
          // A read is serviced even alongside a clear request, using the
          // contents as they stand before the sweep starts.
          if (rd_en) begin
            rd_valid <= 1'b1;
            if (rd_in_range) begin
              rd_data <= bypass_hit ? wr_data : mem[rd_addr];
            end else begin
              rd_data  <= '0;
              addr_err <= 1'b1;
            end
          end

          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
            if (wr_en) begin
              drop <= 1'b1;
            end
          end else if (wr_en) begin
            if (wr_in_range) begin
              mem[wr_addr] <= wr_data;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end

        CLEAR: begin
          mem[ptr] <= '0;
          if (wr_en || rd_en) begin
            drop <= 1'b1;
          end
          if (ptr == LAST_PTR) begin
            state    <= IDLE;
            ptr      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_bank.sv
// tb_memory_bank: drives a DEPTH=16 and a DEPTH=12 memory_bank from shared
// stimulus and compares both against a behavioural model every cycle, plus
// a directed vector table and hand-written clear/reset sequences.
module tb_memory_bank;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       rd_en;
  logic [3:0] rd_addr;
  logic       clr_req;

  logic [3:0] rd_data_o [2];
  logic [1:0] rd_valid_o;
  logic [1:0] busy_o;
  logic [1:0] done_o;
  logic [1:0] drop_o;
  logic [1:0] err_o;

  int total = 0;
  int bad   = 0;

  memory_bank #(.WIDTH(4), .DEPTH(16), .ADDR_W(4)) dut16 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_o[0]), .rd_valid(rd_valid_o[0]),
    .clr_req(clr_req), .busy(busy_o[0]), .clr_done(done_o[0]),
    .drop(drop_o[0]), .addr_err(err_o[0])
  );

  memory_bank #(.WIDTH(4), .DEPTH(12), .ADDR_W(4)) dut12 (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_o[1]), .rd_valid(rd_valid_o[1]),
    .clr_req(clr_req), .busy(busy_o[1]), .clr_done(done_o[1]),
    .drop(drop_o[1]), .addr_err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays plus a countdown of remaining sweep cycles.
  int         depth_of [2];
  logic [3:0] m [2][16];
  int         busy_left [2];
  logic [3:0] e_data [2];
  logic [1:0] e_valid, e_busy, e_done, e_drop, e_err;

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 16; a++) m[k][a] = 4'h0;
      busy_left[k] = 0;
      e_data[k]    = 4'h0;
    end
    e_valid = '0; e_busy = '0; e_done = '0; e_drop = '0; e_err = '0;
  endtask

  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      int d;
      d = depth_of[k];
      e_valid[k] = 1'b0; e_done[k] = 1'b0; e_drop[k] = 1'b0; e_err[k] = 1'b0;
      if (busy_left[k] > 0) begin
        m[k][d - busy_left[k]] = 4'h0;
        busy_left[k]--;
        if (busy_left[k] == 0) e_done[k] = 1'b1;
        if (wr_en || rd_en) e_drop[k] = 1'b1;
      end else begin
        if (rd_en) begin
          e_valid[k] = 1'b1;
          if (int'(rd_addr) < d) begin
            if (wr_en && !clr_req && wr_addr == rd_addr) e_data[k] = wr_data;
            else e_data[k] = m[k][rd_addr];
          end else begin
            e_data[k] = 4'h0;
            e_err[k]  = 1'b1;
          end
        end
        if (clr_req) begin
          busy_left[k] = d;
          if (wr_en) e_drop[k] = 1'b1;
        end else if (wr_en) begin
          if (int'(wr_addr) < d) m[k][wr_addr] = wr_data;
          else e_err[k] = 1'b1;
        end
      end
      e_busy[k] = (busy_left[k] > 0);
    end
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s dut%0d t=%0t got=%0h expected=%0h",
               name, k, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      check("rd_data",  k, 32'(rd_data_o[k]),  32'(e_data[k]));
      check("rd_valid", k, 32'(rd_valid_o[k]), 32'(e_valid[k]));
      check("busy",     k, 32'(busy_o[k]),     32'(e_busy[k]));
      check("clr_done", k, 32'(done_o[k]),     32'(e_done[k]));
      check("drop",     k, 32'(drop_o[k]),     32'(e_drop[k]));
      check("addr_err", k, 32'(err_o[k]),      32'(e_err[k]));
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [3:0] wa,
                               input logic [3:0] wd, input logic r,
                               input logic [3:0] ra, input logic c);
    wr_en = w; wr_addr = wa; wr_data = wd;
    rd_en = r; rd_addr = ra; clr_req = c;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
  endtask

  typedef struct packed {
    logic       w;
    logic [3:0] wa;
    logic [3:0] wd;
    logic       r;
    logic [3:0] ra;
    logic       c;
    logic [3:0] d16;
    logic [3:0] d12;
    logic       v;
    logic       err16;
    logic       err12;
    logic       dr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    int edges;

    depth_of[0] = 16;
    depth_of[1] = 12;

    //            w   wa    wd    r   ra    c   d16   d12   v  e16 e12 dr
    vecs[0]  = '{1'b1, 4'd3,  4'hA, 1'b0, 4'd0,  1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd3,  1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd5,  1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd7,  4'h9, 1'b0, 4'd0,  1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 4'd7,  4'h5, 1'b1, 4'd7,  1'b0, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd7,  1'b0, 4'h5, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'd13, 4'h6, 1'b0, 4'd0,  1'b0, 4'h5, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd13, 1'b0, 4'h6, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 4'd13, 4'h3, 1'b1, 4'd13, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd13, 1'b0, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd0,  4'h0, 1'b1, 4'd3,  1'b0, 4'hA, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b0;
    wr_en = 1'b0; wr_addr = 4'h0; wr_data = 4'h0;
    rd_en = 1'b0; rd_addr = 4'h0; clr_req = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    checkOutput();
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].w, vecs[i].wa, vecs[i].wd, vecs[i].r, vecs[i].ra, vecs[i].c);
      check("vec_d16",   i, 32'(rd_data_o[0]), 32'(vecs[i].d16));
      check("vec_d12",   i, 32'(rd_data_o[1]), 32'(vecs[i].d12));
      check("vec_valid", i, 32'(rd_valid_o),   {30'b0, vecs[i].v, vecs[i].v});
      check("vec_err16", i, 32'(err_o[0]),     32'(vecs[i].err16));
      check("vec_err12", i, 32'(err_o[1]),     32'(vecs[i].err12));
      check("vec_drop",  i, 32'(drop_o),       {30'b0, vecs[i].dr, vecs[i].dr});
    end

    // Clear sweep: fill with 0xF, clear with a same-cycle read of pre-clear data
    for (int a = 0; a < 16; a++) applyStimulus(1'b1, 4'(a), 4'hF, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'd3, 1'b1);
    check("clr_rd_data",  0, 32'(rd_data_o[0]),  32'hF);
    check("clr_rd_valid", 0, 32'(rd_valid_o[0]), 32'h1);
    check("clr_rd_drop",  0, 32'(drop_o[0]),     32'h0);
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o[0]) busy_cnt++;
      if (done_o[0]) begin
        done_cnt++;
        break;
      end
      idle();
    end
    check("busy_cycles", 0, 32'(busy_cnt), 32'd16);
    check("done_pulses", 0, 32'(done_cnt), 32'd1);
    idle();
    check("done_one_cycle", 0, 32'(done_o[0]), 32'h0);
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'(a), 1'b0);
      check("post_clear_rd", a, 32'(rd_data_o[0]), 32'h0);
    end

    // Accesses while busy, clear+write collision, ignored re-request
    applyStimulus(1'b1, 4'd2, 4'h7, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b1, 4'd5, 4'h4, 1'b0, 4'h0, 1'b1);
    check("clr_wr_drop", 0, 32'(drop_o[0]), 32'h1);
    repeat (3) idle();
    applyStimulus(1'b1, 4'd2, 4'h3, 1'b0, 4'h0, 1'b0);
    check("busy_wr_drop",  0, 32'(drop_o[0]),     32'h1);
    check("busy_wr_valid", 0, 32'(rd_valid_o[0]), 32'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    edges = 5;
    for (int i = 0; i < 40; i++) begin
      if (done_o[0]) break;
      idle();
      edges++;
    end
    check("sweep_len", 0, 32'(edges), 32'd16);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'd2, 1'b0);
    check("busy_wr_lost", 0, 32'(rd_data_o[0]), 32'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'd5, 1'b0);
    check("clr_wr_lost", 0, 32'(rd_data_o[0]), 32'h0);

    // Reset mid-clear
    applyStimulus(1'b1, 4'd4, 4'h9, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b1);
    repeat (5) idle();
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput();
    check("rst_busy", 0, 32'(busy_o), 32'h0);
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b1;
    idle();
    check("rst_no_done", 0, 32'(done_o), 32'h0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'd4, 1'b0);
    check("rst_zeroed", 0, 32'(rd_data_o[0]), 32'h0);
    applyStimulus(1'b1, 4'd4, 4'hB, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b1, 4'd4, 1'b0);
    check("rst_then_rw", 0, 32'(rd_data_o[0]), 32'hB);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
